// File: rtl/kalman_axis_sequencer.sv
// Kalman attitude pipeline main sequencer.
// Grants per-axis update requests round-robin and walks the granted axis
// through load -> filter -> latch -> output, with a filter watchdog,
// a sticky timeout flag and abort on loss of sensor configuration.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a pending axis while configured
// S_LOAD   | one-cycle sensor read / preprocessor load for cur
// S_CALC   | filter core for cur running, watchdog counting
// S_LATCH  | one-cycle result latch strobe for cur
// S_OUTPUT | output writer enabled until it reports done
// S_ABORT  | one-cycle watchdog abort, raises timeout_err
module kalman_axis_sequencer #(
    parameter int NUM_AXES       = 3,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                configured,
    input  logic [NUM_AXES-1:0] axis_req,
    input  logic                kalman_done,
    input  logic                output_done,
    input  logic                err_clr,
    output logic [NUM_AXES-1:0] axis_read,
    output logic [NUM_AXES-1:0] load_pre,
    output logic [NUM_AXES-1:0] run_enable,
    output logic [NUM_AXES-1:0] latch,
    output logic                clear,
    output logic                write_enable,
    output logic [SEL_W-1:0]    output_sel,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CALC   = 3'd2,
        S_LATCH  = 3'd3,
        S_OUTPUT = 3'd4,
        S_ABORT  = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0] PTR_INIT   = SEL_W'(NUM_AXES - 1);
    // Down-counter preload: reaching zero on the TIMEOUT_CYCLES-th CALC cycle.
    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_AXES-1:0] req_prev;
    logic [NUM_AXES-1:0] pending;
    logic [NUM_AXES-1:0] req_rise;
    logic [NUM_AXES-1:0] cur_onehot;
    logic [NUM_AXES-1:0] grant_clr;
    logic [SEL_W-1:0]    cur;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    cand;
    logic                grant_vld;
    logic                grant_take;
    logic [CNT_W-1:0]    timer;
    logic                timer_tc;

    assign req_rise   = axis_req & ~req_prev;
    assign cur_onehot = NUM_AXES'(1) << cur;
    assign timer_tc   = (timer == '0);
    assign grant_take = (state == S_IDLE) && configured && grant_vld;
    assign grant_clr  = grant_take ? (NUM_AXES'(1) << grant_idx) : '0;

    // Round-robin pick: scan from farthest to nearest so the nearest pending
    // index after rr_ptr overwrites any farther candidate.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_AXES; k >= 1; k--) begin
            cand = SEL_W'((int'(rr_ptr) + k) % NUM_AXES);
            if (pending[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; done beats a same-cycle watchdog expiry in CALC.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant_take) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = configured ? S_CALC : S_IDLE;
            S_CALC: begin
                if (kalman_done)     state_nxt = S_LATCH;
                else if (timer_tc)   state_nxt = S_ABORT;
                else if (!configured) state_nxt = S_IDLE;
            end
            S_LATCH:  state_nxt = S_OUTPUT;
            S_OUTPUT: if (output_done) state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and current axis.
    always_comb begin
        axis_read    = '0;
        load_pre     = '0;
        run_enable   = '0;
        latch        = '0;
        clear        = 1'b1;
        write_enable = 1'b0;
        output_sel   = cur;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE:   output_sel = '0;
            S_LOAD: begin
                axis_read = cur_onehot;
                load_pre  = cur_onehot;
            end
            S_CALC: begin
                run_enable = cur_onehot;
                clear      = 1'b0;
            end
            S_LATCH:  latch = cur_onehot;
            S_OUTPUT: write_enable = 1'b1;
            default: ;
        endcase
    end

    // Request edge capture, pending set/clear (set wins) and grant bookkeeping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            req_prev <= '0;
            pending  <= '0;
            cur      <= '0;
            rr_ptr   <= PTR_INIT;
        end else begin
            req_prev <= axis_req;
            pending  <= (pending & ~grant_clr) | req_rise;
            if (grant_take) begin
                cur    <= grant_idx;
                rr_ptr <= grant_idx;
            end
        end
    end

    // Filter watchdog: preloaded in LOAD, counts down while in CALC.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer <= '0;
        end else if (state == S_LOAD) begin
            timer <= TIMER_LOAD;
        end else if (state == S_CALC && !timer_tc) begin
            timer <= timer - 1'b1;
        end
    end

    // Sticky watchdog flag; an abort beats a simultaneous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timeout_err <= 1'b0;
        end else if (state == S_ABORT) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kalman_axis_sequencer.sv
// Self-checking bench for kalman_axis_sequencer (3 axes, 8-cycle watchdog).
module tb_kalman_axis_sequencer;

    localparam int NA = 3;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        configured;
    logic [2:0]  axis_req;
    logic        kalman_done;
    logic        output_done;
    logic        err_clr;
    logic [2:0]  axis_read;
    logic [2:0]  load_pre;
    logic [2:0]  run_enable;
    logic [2:0]  latch;
    logic        clear;
    logic        write_enable;
    logic [1:0]  output_sel;
    logic        busy;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model: pending requests, last served axis, sticky error.
    logic [2:0]  m_pend;
    int          m_rr;
    logic        m_err;

    kalman_axis_sequencer #(
        .NUM_AXES(NA), .SEL_W(2), .TIMEOUT_CYCLES(TO), .CNT_W(4)
    ) dut (
        .clk(clk), .n_rst(n_rst), .configured(configured), .axis_req(axis_req),
        .kalman_done(kalman_done), .output_done(output_done), .err_clr(err_clr),
        .axis_read(axis_read), .load_pre(load_pre), .run_enable(run_enable),
        .latch(latch), .clear(clear), .write_enable(write_enable),
        .output_sel(output_sel), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] pend, input int ptr);
        logic [2:0] t;
        for (int k = 1; k <= NA; k++) begin
            t = pend >> ((ptr + k) % NA);
            if (t[0]) return (ptr + k) % NA;
        end
        return 0;
    endfunction

    function automatic logic [2:0] oh(input int i);
        return 3'(1 << i);
    endfunction

    task automatic set_req(input logic [2:0] v);
        m_pend   = m_pend | (v & ~axis_req);
        axis_req = v;
    endtask

    task automatic wait_load(output int ax);
        int i;
        ax = rr_pick(m_pend, m_rr);
        i  = 0;
        while (axis_read == 3'b000 && i < 20) begin
            tick();
            i++;
        end
        chk("load_seen", 32'(axis_read != 3'b000), 32'd1);
        m_pend[ax] = 1'b0;
        m_rr       = ax;
        chk("load_axis_read", 32'(axis_read), 32'(oh(ax)));
        chk("load_pre", 32'(load_pre), 32'(oh(ax)));
        chk("load_sel", 32'(output_sel), 32'(ax));
        chk("load_clear", 32'(clear), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
    endtask

    task automatic txn(input int done_d, input int out_d, input bit chg, input logic [2:0] nreq);
        int ax;
        int c;
        int w;
        wait_load(ax);
        if (chg) set_req(nreq);
        tick();
        c = 0;
        do begin
            c++;
            chk("calc_run", 32'(run_enable), 32'(oh(ax)));
            chk("calc_clear", 32'(clear), 32'd0);
            chk("calc_wen", 32'(write_enable | (|latch) | (|axis_read)), 32'd0);
            kalman_done = (c == done_d);
            tick();
            kalman_done = 1'b0;
        end while ((done_d == 0 || c < done_d) && c < TO);
        if (done_d == 0) begin
            chk("abort_busy", 32'(busy), 32'd1);
            chk("abort_clear", 32'(clear), 32'd1);
            chk("abort_strobes", 32'({run_enable, latch, axis_read, write_enable}), 32'd0);
            err_clr = 1'($urandom % 2);
            tick();
            err_clr = 1'b0;
            m_err   = 1'b1;
            chk("abort_err", 32'(timeout_err), 32'd1);
            chk("abort_idle", 32'(busy), 32'd0);
        end else begin
            chk("latch", 32'(latch), 32'(oh(ax)));
            chk("latch_run", 32'(run_enable), 32'd0);
            chk("latch_wen", 32'(write_enable), 32'd0);
            tick();
            w = 0;
            do begin
                w++;
                chk("out_wen", 32'(write_enable), 32'd1);
                chk("out_sel", 32'(output_sel), 32'(ax));
                chk("out_latch", 32'(latch), 32'd0);
                output_done = (w == out_d);
                tick();
                output_done = 1'b0;
            end while (w < out_d);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_wen", 32'(write_enable), 32'd0);
            chk("end_sel", 32'(output_sel), 32'd0);
            chk("end_err", 32'(timeout_err), 32'(m_err));
        end
    endtask

    initial begin
        int ax;
        axis_req = '0; configured = 1'b1; kalman_done = 1'b0;
        output_done = 1'b0; err_clr = 1'b0; n_rst = 1'b0;
        m_pend = '0; m_rr = NA - 1; m_err = 1'b0;

        // Reset values
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clear", 32'(clear), 32'd1);
        chk("rst_sel", 32'(output_sel), 32'd0);
        chk("rst_strobes", 32'({axis_read, load_pre, run_enable, latch, write_enable}), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        repeat (2) tick();
        n_rst = 1'b1;
        tick();

        // T2 round-robin from reset pointer, then 101
        set_req(3'b111);
        repeat (3) txn(1 + int'($urandom_range(0, 3)), 1, 1'b0, 3'b000);
        set_req(3'b000);
        tick();
        set_req(3'b101);
        repeat (2) txn(2, 1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_no_extra", 32'(busy), 32'd0);
        end

        // T1 single axis: 4 CALC cycles, 2 OUTPUT cycles
        set_req(3'b000);
        tick();
        set_req(3'b001);
        txn(4, 2, 1'b0, 3'b000);

        // T5 new edge in LOAD re-serves; held level served once
        set_req(3'b000);
        tick();
        set_req(3'b001);
        tick();
        set_req(3'b000);
        txn(2, 1, 1'b1, 3'b001);
        txn(1, 1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("level_once", 32'(busy), 32'd0);
        end

        // T3 watchdog abort, clear, then done on the last allowed cycle
        set_req(3'b000);
        tick();
        set_req(3'b010);
        txn(0, 1, 1'b0, 3'b000);
        repeat (2) tick();
        chk("err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_cleared", 32'(timeout_err), 32'd0);
        set_req(3'b000);
        tick();
        set_req(3'b010);
        txn(TO, 1, 1'b0, 3'b000);

        // T4 configuration drop in CALC keeps other pending axes
        set_req(3'b000);
        tick();
        set_req(3'b110);
        wait_load(ax);
        tick();
        chk("cfg_calc", 32'(run_enable), 32'(oh(ax)));
        configured = 1'b0;
        tick();
        chk("cfg_drop_idle", 32'(busy), 32'd0);
        chk("cfg_drop_err", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cfg_hold", 32'(busy), 32'd0);
        end
        configured = 1'b1;
        txn(3, 1, 1'b0, 3'b000);
        set_req(3'b000);
        tick();
        set_req(3'b001);
        wait_load(ax);
        configured = 1'b0;
        tick();
        chk("cfg_load_drop", 32'(busy), 32'd0);
        configured = 1'b1;
        tick();
        tick();
        chk("cfg_load_no_regrant", 32'(busy), 32'd0);

        // T6 async reset in OUTPUT discards pending requests
        set_req(3'b000);
        tick();
        set_req(3'b100);
        wait_load(ax);
        tick();
        set_req(3'b111);
        kalman_done = 1'b1;
        tick();
        kalman_done = 1'b0;
        tick();
        chk("rst_pre_out", 32'(write_enable), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_clear", 32'(clear), 32'd1);
        chk("rst_mid_wen", 32'(write_enable), 32'd0);
        axis_req = 3'b000; m_pend = '0; m_rr = NA - 1; m_err = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_discard", 32'(busy), 32'd0);
        end

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            if (m_pend == 3'b000) begin
                set_req(3'b000);
                tick();
                set_req(3'($urandom_range(1, 7)));
            end
            txn(($urandom % 5 == 0) ? 0 : int'($urandom_range(1, TO)),
                int'($urandom_range(1, 3)), 1'b1, 3'($urandom));
            if ($urandom % 4 == 0) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                m_err = 1'b0;
                chk("rand_err_clr", 32'(timeout_err), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
